// File: rtl/csr_timer.sv
// CSR-mapped countdown timer with one-shot/periodic modes, a level interrupt
// cleared through TICLR, and a free-running 64-bit stable counter.
`timescale 1ns/1ps
module csr_timer #(
  parameter logic [13:0] TCFG_ADDR  = 14'h041,
  parameter logic [13:0] TVAL_ADDR  = 14'h042,
  parameter logic [13:0] TICLR_ADDR = 14'h044
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_addr,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        timer_int,
  output logic [63:0] stable_cnt
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        tis_q, tis_d;
  logic [63:0] stable_cnt_q, stable_cnt_d;

  logic        en;
  logic        periodic;
  logic [31:0] reload;
  logic        tick;
  logic        tcfg_wr;
  logic        ticlr_wr;

  assign en       = tcfg_q[0];
  assign periodic = tcfg_q[1];
  assign reload   = {tcfg_q[31:2], 2'b00};
  assign tick     = en && (tval_q == 32'd1);
  assign tcfg_wr  = csr_wen && (csr_addr == TCFG_ADDR);
  assign ticlr_wr = csr_wen && (csr_addr == TICLR_ADDR) && csr_wdata[0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    tcfg_d       = tcfg_q;
    tval_d       = tval_q;
    tis_d        = tis_q;
    stable_cnt_d = stable_cnt_q + 64'd1;

    // A zero TVAL never matches the tick or decrement terms, so it simply holds.
    if (tick) begin
      tval_d = periodic ? reload : 32'd0;
    end else if (en && (tval_q > 32'd1)) begin
      tval_d = tval_q - 32'd1;
    end

    // A configuration write overrides any countdown or reload on the same edge.
    if (tcfg_wr) begin
      tcfg_d = csr_wdata;
      tval_d = {csr_wdata[31:2], 2'b00};
    end

    // Set is evaluated last so a tick beats a simultaneous clear.
    if (ticlr_wr) tis_d = 1'b0;
    if (tick)     tis_d = 1'b1;
  end

  always_comb begin
    csr_rdata = 32'd0;
    csr_hit   = 1'b0;
    if (csr_addr == TCFG_ADDR) begin
      csr_rdata = tcfg_q;
      csr_hit   = 1'b1;
    end else if (csr_addr == TVAL_ADDR) begin
      csr_rdata = tval_q;
      csr_hit   = 1'b1;
    end else if (csr_addr == TICLR_ADDR) begin
      csr_hit   = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_q       <= 32'd0;
      tval_q       <= 32'd0;
      tis_q        <= 1'b0;
      stable_cnt_q <= 64'd0;
    end else begin
      tcfg_q       <= tcfg_d;
      tval_q       <= tval_d;
      tis_q        <= tis_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign timer_int  = tis_q;
  assign stable_cnt = stable_cnt_q;

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: table vectors, directed corner sequences
// and randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_csr_timer;

  localparam logic [13:0] TCFG  = 14'h041;
  localparam logic [13:0] TVAL  = 14'h042;
  localparam logic [13:0] TICLR = 14'h044;
  localparam logic [13:0] NONE  = 14'h045;

  logic        clk;
  logic        reset;
  logic [13:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        timer_int;
  logic [63:0] stable_cnt;

  csr_timer dut (
    .clk       (clk),
    .reset     (reset),
    .csr_addr  (csr_addr),
    .csr_wen   (csr_wen),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_hit   (csr_hit),
    .timer_int (timer_int),
    .stable_cnt(stable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: configuration word, remaining count, interrupt flag, cycle count.
  logic [31:0] m_cfg;
  logic [31:0] m_val;
  logic        m_tis;
  logic [63:0] m_cnt;

  function automatic logic m_hit(input logic [13:0] a);
    return (a == TCFG) || (a == TVAL) || (a == TICLR);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    if (a == TCFG) return m_cfg;
    if (a == TVAL) return m_val;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_cfg = '0;
    m_val = '0;
    m_tis = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_edge(input logic [13:0] a, input logic w, input logic [31:0] d);
    logic [31:0] r;
    logic        fires;
    logic [31:0] nxt;
    r     = m_cfg & 32'hFFFF_FFFC;
    fires = m_cfg[0] && (m_val == 32'd1);
    nxt   = m_val;
    if (m_cfg[0] && m_val > 32'd1) nxt = m_val - 32'd1;
    if (fires) nxt = m_cfg[1] ? r : 32'd0;
    if (w && a == TCFG) begin
      m_cfg = d;
      nxt   = d & 32'hFFFF_FFFC;
    end
    if (w && a == TICLR && d[0]) m_tis = 1'b0;
    if (fires) m_tis = 1'b1;
    m_val = nxt;
    m_cnt = m_cnt + 64'd1;
  endtask

  logic [31:0] pre_rdata;
  logic        pre_hit;

  // Called between edges: drives one CSR access, checks the combinational
  // response, then takes one rising edge and checks the registered outputs.
  task automatic cycle(input logic [13:0] a, input logic w, input logic [31:0] d);
    csr_addr  = a;
    csr_wen   = w;
    csr_wdata = d;
    #1;
    pre_rdata = csr_rdata;
    pre_hit   = csr_hit;
    check("rdata", {32'd0, csr_rdata}, {32'd0, m_read(a)});
    check("hit", {63'd0, csr_hit}, {63'd0, m_hit(a)});
    @(posedge clk);
    model_edge(a, w, d);
    #1;
    check("timer_int", {63'd0, timer_int}, {63'd0, m_tis});
    check("stable_cnt", stable_cnt, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    csr_wen = 1'b0;
    model_reset();
    csr_addr = TCFG;
    #1;
    check("rst_int", {63'd0, timer_int}, 64'd0);
    check("rst_cnt", stable_cnt, 64'd0);
    check("rst_tcfg", {32'd0, csr_rdata}, 64'd0);
    csr_addr = TVAL;
    #1;
    check("rst_tval", {32'd0, csr_rdata}, 64'd0);
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [13:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_int;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset     = 1'b0;
    csr_addr  = '0;
    csr_wen   = 1'b0;
    csr_wdata = '0;
    model_reset();

    vecs[0] = '{TCFG,  1'b0, 32'h0,         32'h0,  1'b1, 1'b0};
    vecs[1] = '{NONE,  1'b1, 32'hFFFF_FFFF, 32'h0,  1'b0, 1'b0};
    vecs[2] = '{TVAL,  1'b1, 32'hFFFF_FFFF, 32'h0,  1'b1, 1'b0};
    vecs[3] = '{TICLR, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0};
    vecs[4] = '{TCFG,  1'b1, 32'h0000_000D, 32'h0,  1'b1, 1'b0};
    vecs[5] = '{TCFG,  1'b0, 32'h0,         32'hD,  1'b1, 1'b0};
    vecs[6] = '{TVAL,  1'b0, 32'h0,         32'd11, 1'b1, 1'b0};
    vecs[7] = '{TVAL,  1'b1, 32'h0,         32'd10, 1'b1, 1'b0};
    vecs[8] = '{TVAL,  1'b0, 32'h0,         32'd9,  1'b1, 1'b0};
    vecs[9] = '{14'h0, 1'b0, 32'h0,         32'h0,  1'b0, 1'b0};

    // Table vectors straight after reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].addr, vecs[i].wen, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), {32'd0, pre_rdata}, {32'd0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_hit", i), {63'd0, pre_hit}, {63'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_int", i), {63'd0, timer_int}, {63'd0, vecs[i].exp_int});
    end

    // One-shot R=16: TVAL counts 16..1 then sticks at 0, interrupt 16 edges after the write.
    do_reset();
    cycle(TCFG, 1'b1, 32'h0000_0011);
    for (int k = 0; k < 20; k++) begin
      cycle(TVAL, 1'b0, 32'h0);
      check("oneshot_tval", {32'd0, pre_rdata}, (k <= 16) ? 64'(16 - k) : 64'd0);
      check("oneshot_int", {63'd0, timer_int}, {63'd0, (k >= 15)});
    end

    // Periodic R=8 with TICLR after each rise.
    do_reset();
    cycle(TCFG, 1'b1, 32'h0000_000B);
    for (int e = 1; e <= 33; e++) begin
      if (timer_int) begin
        cycle(TICLR, 1'b1, 32'h1);
      end else begin
        cycle(TVAL, 1'b0, 32'h0);
        check("periodic_tval", {32'd0, pre_rdata}, 64'(8 - ((e - 1) % 8)));
      end
      check("periodic_int", {63'd0, timer_int}, {63'd0, (e % 8 == 0)});
    end

    // Tick and TICLR in the same cycle: set wins; clear lands one cycle later.
    do_reset();
    cycle(TCFG, 1'b1, 32'h0000_0009);
    for (int k = 0; k < 7; k++) cycle(TVAL, 1'b0, 32'h0);
    check("coll_tval1", {32'd0, pre_rdata}, 64'd2);
    cycle(TICLR, 1'b1, 32'h1);
    check("coll_set_wins", {63'd0, timer_int}, 64'd1);
    cycle(TICLR, 1'b1, 32'hFFFF_FFFF);
    check("coll_clear", {63'd0, timer_int}, 64'd0);

    // Tick and TCFG write in the same cycle: interrupt set, TVAL takes new R.
    do_reset();
    cycle(TCFG, 1'b1, 32'h0000_000B);
    for (int k = 0; k < 7; k++) cycle(TVAL, 1'b0, 32'h0);
    cycle(TCFG, 1'b1, 32'h0000_0015);
    check("tcfg_tick_int", {63'd0, timer_int}, 64'd1);
    cycle(TVAL, 1'b0, 32'h0);
    check("tcfg_tick_tval", {32'd0, pre_rdata}, 64'd20);

    // Pause at TVAL=5: reload R=16 and hold, no interrupt.
    do_reset();
    cycle(TCFG, 1'b1, 32'h0000_0011);
    for (int k = 0; k < 11; k++) cycle(TVAL, 1'b0, 32'h0);
    cycle(TVAL, 1'b0, 32'h0);
    check("pause_at5", {32'd0, pre_rdata}, 64'd5);
    cycle(TCFG, 1'b1, 32'h0000_0010);
    for (int k = 0; k < 50; k++) begin
      cycle(TVAL, 1'b0, 32'h0);
      check("pause_tval", {32'd0, pre_rdata}, 64'd16);
      check("pause_int", {63'd0, timer_int}, 64'd0);
    end

    // Reset while TVAL=3 and stable_cnt=100.
    do_reset();
    for (int k = 0; k < 86; k++) cycle(TVAL, 1'b0, 32'h0);
    cycle(TCFG, 1'b1, 32'h0000_0011);
    for (int k = 0; k < 13; k++) cycle(TVAL, 1'b0, 32'h0);
    csr_addr = TVAL;
    csr_wen  = 1'b0;
    #1;
    check("prerst_tval", {32'd0, csr_rdata}, 64'd3);
    check("prerst_cnt", stable_cnt, 64'd100);
    do_reset();
    for (int k = 0; k < 100; k++) begin
      cycle(TVAL, 1'b0, 32'h0);
      if (k == 0) check("postrst_cnt1", stable_cnt, 64'd1);
      check("postrst_tval", {32'd0, pre_rdata}, 64'd0);
      check("postrst_int", {63'd0, timer_int}, 64'd0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int unsigned sel;
      logic [13:0] ra;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        do_reset();
      end else if (sel <= 3) begin
        cycle(TCFG, 1'b1, 32'($urandom_range(0, 63)));
      end else if (sel <= 5) begin
        cycle(TICLR, 1'b1, 32'($urandom));
      end else if (sel == 6) begin
        cycle(TVAL, 1'b1, 32'($urandom));
      end else if (sel == 7) begin
        ra = 14'($urandom);
        if (m_hit(ra)) ra = NONE;
        cycle(ra, 1'b1, 32'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0:       ra = TCFG;
          1:       ra = TVAL;
          2:       ra = TICLR;
          default: ra = 14'($urandom);
        endcase
        cycle(ra, 1'b0, 32'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
